// File: rtl/opl3_timer_bank.sv
// opl3_timer_bank
//   Timer bank for the OPL3 core. A fractional accumulator turns clk into a
//   base tick whose long-run rate is exactly BASE_TICK_HZ. A shared free-running
//   prescaler divides that tick per timer, and NUM_TIMERS preloadable up-counters
//   raise sticky overflow flags that are OR-ed onto a single irq.
//
// Ports
//   clk        system clock (CLK_FREQ Hz)
//   reset_n    asynchronous active-low reset
//   preload    per-timer reload value, timer i at [i*TIMER_WIDTH +: TIMER_WIDTH]
//   start      per-timer run level; a rising edge loads preload
//   mask       per-timer: 1 = overflow does not set the flag
//   oneshot    per-timer: 1 = timer halts after its first overflow
//   irq_rst    one-cycle pulse, clears all flags
//   base_tick  one-cycle base tick pulse
//   cnt        current counter values, same packing as preload
//   flag       sticky overflow flags
//   irq        OR of flag

module opl3_timer_bank #(
  parameter int CLK_FREQ       = 12727000,
  parameter int BASE_TICK_HZ   = 12500,
  parameter int NUM_TIMERS     = 2,
  parameter int TIMER_WIDTH    = 8,
  parameter int PRESCALE_SHIFT = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_TIMERS*TIMER_WIDTH-1:0] preload,
  input  logic [NUM_TIMERS-1:0]             start,
  input  logic [NUM_TIMERS-1:0]             mask,
  input  logic [NUM_TIMERS-1:0]             oneshot,
  input  logic                              irq_rst,
  output logic                              base_tick,
  output logic [NUM_TIMERS*TIMER_WIDTH-1:0] cnt,
  output logic [NUM_TIMERS-1:0]             flag,
  output logic                              irq
);

  // acc stays below CLK_FREQ, so acc + BASE_TICK_HZ < 2*CLK_FREQ fits in ACC_W bits.
  localparam int ACC_W     = $clog2(CLK_FREQ) + 1;
  localparam int PRE_W_RAW = PRESCALE_SHIFT * (NUM_TIMERS - 1);
  localparam int PRE_W     = (PRE_W_RAW < 1) ? 1 : PRE_W_RAW;

  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(BASE_TICK_HZ);
  localparam logic [ACC_W-1:0] ACC_WRAP = ACC_W'(CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [PRE_W-1:0] pre;

  assign acc_sum = acc + ACC_STEP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      base_tick <= 1'b0;
      pre       <= '0;
    end else begin
      if (acc_sum >= ACC_WRAP) begin
        acc       <= acc_sum - ACC_WRAP;
        base_tick <= 1'b1;
      end else begin
        acc       <= acc_sum;
        base_tick <= 1'b0;
      end
      // Never cleared by start, so a timer's first interval depends on pre phase.
      if (base_tick) pre <= pre + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    // Timer i ticks when the low PRESCALE_SHIFT*i prescaler bits are all ones;
    // for timer 0 the mask is empty and every base tick counts.
    localparam int               SH       = PRESCALE_SHIFT * i;
    localparam logic [PRE_W-1:0] PRE_MASK = PRE_W'((64'd1 << SH) - 64'd1);

    logic [TIMER_WIDTH-1:0] cnt_q;
    logic [TIMER_WIDTH-1:0] load_val;
    logic                   run_q;
    logic                   start_q;
    logic                   flag_q;
    logic                   tick_i;
    logic                   rise;
    logic                   ovf;

    assign tick_i   = base_tick & ((pre & PRE_MASK) == PRE_MASK);
    assign load_val = preload[i*TIMER_WIDTH +: TIMER_WIDTH];
    assign rise     = start[i] & ~start_q;
    // A load or a stop in the same cycle takes priority over the tick.
    assign ovf      = start[i] & ~rise & run_q & tick_i & (cnt_q == '1);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        run_q   <= 1'b0;
        start_q <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        start_q <= start[i];

        if (rise) begin
          cnt_q <= load_val;
          run_q <= 1'b1;
        end else if (!start[i]) begin
          run_q <= 1'b0;
        end else if (run_q && tick_i) begin
          if (ovf) begin
            cnt_q <= load_val;
            if (oneshot[i]) run_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + TIMER_WIDTH'(1);
          end
        end

        // Set beats clear so an overflow coincident with irq_rst is not lost.
        if (ovf && !mask[i]) begin
          flag_q <= 1'b1;
        end else if (irq_rst) begin
          flag_q <= 1'b0;
        end
      end
    end

    assign cnt[i*TIMER_WIDTH +: TIMER_WIDTH] = cnt_q;
    assign flag[i]                           = flag_q;
  end

  assign irq = |flag;

endmodule

// File: doc/opl3_timer_bank.md
# opl3_timer_bank

Parametrised timer bank for the OPL3 core: generates an exact-average base tick from the system clock by fractional accumulation, then drives NUM_TIMERS up-counting preloadable timers with per-timer prescale, mask, one-shot mode and a shared IRQ. It generalises the two fixed OPL3 timers (80 us / 320 us, 8-bit) to any count, width and tick rate. It sits beside the register file, which supplies preload, start, mask and IRQ-reset, and feeds the status register and host IRQ pin.

## Interface
- CLK_FREQ, 12727000: system clock frequency in Hz.
- BASE_TICK_HZ, 12500: base tick rate in Hz (80 us); must satisfy 0 < BASE_TICK_HZ < CLK_FREQ.
- NUM_TIMERS, 2: number of timers, 1..8.
- TIMER_WIDTH, 8: counter/preload width in bits.
- PRESCALE_SHIFT, 2: timer i ticks once every 2^(PRESCALE_SHIFT*i) base ticks.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- preload  in  NUM_TIMERS*TIMER_WIDTH  per-timer reload value, timer i at [i*TIMER_WIDTH +: TIMER_WIDTH].
- start  in  NUM_TIMERS  level; 1 = run, rising edge loads preload.
- mask  in  NUM_TIMERS  1 = overflow does not set flag.
- oneshot  in  NUM_TIMERS  1 = timer halts after first overflow.
- irq_rst  in  1  single-cycle pulse; clears all flags.
- base_tick  out  1  one-cycle base tick pulse.
- cnt  out  NUM_TIMERS*TIMER_WIDTH  current counter values.
- flag  out  NUM_TIMERS  sticky overflow flags.
- irq  out  1  OR of flag.

## Operation
- Fractional tick: accumulator acc, width $clog2(CLK_FREQ)+1. Each cycle: if acc + BASE_TICK_HZ >= CLK_FREQ then acc <= acc + BASE_TICK_HZ - CLK_FREQ and base_tick <= 1, else acc <= acc + BASE_TICK_HZ and base_tick <= 0. Exactly BASE_TICK_HZ ticks per CLK_FREQ cycles, no drift.
- Prescaler: free-running counter pre, width PRESCALE_SHIFT*(NUM_TIMERS-1) (min 1), increments on base_tick, wraps. Never reset by start, so first interval of timer i>0 is 1..2^(PRESCALE_SHIFT*i) base ticks.
- Timer tick t_i = base_tick AND low PRESCALE_SHIFT*i bits of pre all ones (timer 0: t_0 = base_tick).
- Per timer, state bits: run, start_q (registered start).
  - start rising (start & ~start_q): cnt <= preload, run <= 1; a coincident t_i is ignored.
  - start low: run <= 0, cnt holds.
  - run & t_i & cnt != all-ones: cnt <= cnt + 1.
  - run & t_i & cnt == all-ones (overflow): cnt <= preload; if ~mask, flag <= 1; if oneshot, run <= 0 (re-arm needs start 0 then 1).
- Masking only gates setting; an already-set flag persists when mask rises.
- irq_rst clears all flags; an overflow in the same cycle sets its flag (set wins, no lost event).
- Preload changes while running take effect at next load only.

## Timing
- Reset values: acc=0, pre=0, base_tick=0, cnt=0, flag=0, irq=0, run=0, start_q=0.
- All outputs registered except irq = |flag (combinational from registers; no extra latency).
- base_tick asserted the cycle after the accumulator crossing is computed; t_i effects on cnt/flag visible the cycle after base_tick is high.
- start rise at cycle N: cnt = preload at N+1.
- Overflow tick at cycle N: flag and irq high at N+1, cnt = preload at N+1.
- irq_rst at N: flag low at N+1 (unless concurrent overflow).
- reset_n asserted mid-count: all state clears immediately; after release the timer stays idle until a new start rising edge is seen (start held high through reset counts as a rising edge on the first clock after release).

## Test plan
- CLK_FREQ=10, BASE_TICK_HZ=3: over 100 cycles -> exactly 30 base_tick pulses, spacing only 3 or 4 cycles.
- Defaults, preload[0]=0xFF, start[0]=1 -> flag[0] and irq high on the cycle after the first timer-0 tick, cnt[0] reloaded to 0xFF.
- Timer 1, preload=0xFE, PRESCALE_SHIFT=2 -> after the first timer-1 tick, overflow occurs exactly 4 base ticks after the first timer-1 tick; cnt[1] = 0xFE after overflow.
- mask[0]=1, preload 0xFF -> cnt reloads each tick, flag[0] stays 0; set flag, then raise mask -> flag stays 1 until irq_rst.
- oneshot[0]=1 -> single overflow then cnt frozen at preload; start 0->1 re-arms and a second overflow occurs.
- irq_rst coincident with timer-0 overflow -> flag[0]=1 next cycle; irq_rst alone -> all flags 0; reset_n pulse mid-count -> cnt=0, flag=0 immediately.
